// File: rtl/pulse_transmitter_symbol_sequencer.sv
// Symbol sequencer for a pulse transmitter: walks a small table of (level, duration)
// entries, programs an external countdown timer for each one and repeats the pass loop_count times.
module pulse_transmitter_symbol_sequencer #(
    parameter int NUM_SYMBOLS     = 8,
    parameter int TIMER_WIDTH     = 8,
    parameter int PRESCALER_WIDTH = 16,
    localparam int AW             = $clog2(NUM_SYMBOLS),
    localparam int PW             = $clog2(PRESCALER_WIDTH)
) (
    input  logic                   clk,
    input  logic                   sys_rst,
    input  logic                   cfg_we,
    input  logic [AW-1:0]          cfg_addr,
    input  logic [TIMER_WIDTH:0]   cfg_wdata,
    input  logic [PW-1:0]          prescaler_hi,
    input  logic [PW-1:0]          prescaler_lo,
    input  logic [AW:0]            symbol_count,
    input  logic [7:0]             loop_count,
    input  logic                   idle_level,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   timer_pulse,
    output logic                   timer_en,
    output logic [PW-1:0]          timer_prescaler,
    output logic [TIMER_WIDTH-1:0] timer_duration,
    output logic                   tx_out,
    output logic                   busy,
    output logic                   done,
    output logic [AW-1:0]          symbol_index
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    localparam logic [AW:0] MAX_COUNT = NUM_SYMBOLS[AW:0];

    state_t                 state, state_next;
    logic [7:0]             pass_cnt, pass_next;
    logic [AW-1:0]          index_next;
    logic                   timer_en_next;
    logic [PW-1:0]          psc_next;
    logic [TIMER_WIDTH-1:0] dur_next;
    logic                   tx_next;
    logic                   done_next;
    logic                   load_entry;

    logic [TIMER_WIDTH:0]   sym_table [NUM_SYMBOLS];
    logic [AW:0]            eff_count;
    logic [AW:0]            next_pos;
    logic                   last_symbol;
    logic [AW-1:0]          load_index;
    logic [TIMER_WIDTH:0]   entry;

    // NOTE: the symbol table has no reset; it is configuration that must survive sys_rst.
    always_ff @(posedge clk) begin
        if (cfg_we && state == IDLE) begin
            sym_table[cfg_addr] <= cfg_wdata;
        end
    end

    assign eff_count   = (symbol_count > MAX_COUNT) ? MAX_COUNT : symbol_count;
    assign next_pos    = {1'b0, symbol_index} + {{AW{1'b0}}, 1'b1};
    assign last_symbol = (next_pos >= eff_count);

    // A new entry is only ever fetched for the first symbol or the one after the current one.
    assign load_index  = (state == RUN && !last_symbol) ? next_pos[AW-1:0] : '0;
    assign entry       = sym_table[load_index];

    // NOTE: every variable gets a default before the case so no latch can be inferred.
    always_comb begin
        state_next    = state;
        index_next    = symbol_index;
        pass_next     = pass_cnt;
        timer_en_next = timer_en;
        psc_next      = timer_prescaler;
        dur_next      = timer_duration;
        tx_next       = tx_out;
        done_next     = 1'b0;
        load_entry    = 1'b0;

        case (state)
            IDLE: begin
                if (start && !stop) begin
                    if (eff_count != '0) begin
                        state_next = LOAD;
                        index_next = '0;
                        pass_next  = loop_count;
                        load_entry = 1'b1;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (stop) begin
                    state_next    = IDLE;
                    tx_next       = idle_level;
                    timer_en_next = 1'b0;
                end else begin
                    state_next    = RUN;
                    timer_en_next = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_next    = IDLE;
                    tx_next       = idle_level;
                    timer_en_next = 1'b0;
                end else if (timer_pulse) begin
                    if (!last_symbol) begin
                        state_next = LOAD;
                        index_next = next_pos[AW-1:0];
                        load_entry = 1'b1;
                    end else if (pass_cnt != 8'd0) begin
                        state_next = LOAD;
                        index_next = '0;
                        pass_next  = pass_cnt - 8'd1;
                        load_entry = 1'b1;
                    end else begin
                        state_next    = IDLE;
                        done_next     = 1'b1;
                        tx_next       = idle_level;
                        timer_en_next = 1'b0;
                    end
                end
            end
            default: begin
                state_next    = IDLE;
                timer_en_next = 1'b0;
            end
        endcase

        // Timer is held off while the new parameters settle, clearing it between symbols.
        if (load_entry) begin
            timer_en_next = 1'b0;
            dur_next      = entry[TIMER_WIDTH-1:0];
            psc_next      = entry[TIMER_WIDTH] ? prescaler_hi : prescaler_lo;
            tx_next       = entry[TIMER_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state           <= IDLE;
            pass_cnt        <= 8'd0;
            symbol_index    <= '0;
            timer_en        <= 1'b0;
            timer_prescaler <= '0;
            timer_duration  <= '0;
            tx_out          <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            state           <= state_next;
            pass_cnt        <= pass_next;
            symbol_index    <= index_next;
            timer_en        <= timer_en_next;
            timer_prescaler <= psc_next;
            timer_duration  <= dur_next;
            tx_out          <= tx_next;
            busy            <= (state_next != IDLE);
            done            <= done_next;
        end
    end

endmodule

// File: tb/tb_pulse_transmitter_symbol_sequencer.sv
// Scoreboard bench: stimulus pushes expected symbol loads and done pulses, a monitor
// pops them whenever the sequencer presents a LOAD cycle or a done pulse.
module tb_pulse_transmitter_symbol_sequencer;

    localparam int NS  = 8;
    localparam int TW  = 8;
    localparam int PSW = 16;
    localparam int AW  = 3;
    localparam int PW  = 4;

    logic          clk = 1'b0;
    logic          sys_rst;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [TW:0]   cfg_wdata;
    logic [PW-1:0] prescaler_hi, prescaler_lo;
    logic [AW:0]   symbol_count;
    logic [7:0]    loop_count;
    logic          idle_level, start, stop;
    logic          timer_pulse;
    logic          timer_en;
    logic [PW-1:0] timer_prescaler;
    logic [TW-1:0] timer_duration;
    logic          tx_out, busy, done;
    logic [AW-1:0] symbol_index;

    pulse_transmitter_symbol_sequencer #(
        .NUM_SYMBOLS(NS), .TIMER_WIDTH(TW), .PRESCALER_WIDTH(PSW)
    ) dut (
        .clk(clk), .sys_rst(sys_rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .prescaler_hi(prescaler_hi), .prescaler_lo(prescaler_lo),
        .symbol_count(symbol_count), .loop_count(loop_count), .idle_level(idle_level),
        .start(start), .stop(stop), .timer_pulse(timer_pulse), .timer_en(timer_en),
        .timer_prescaler(timer_prescaler), .timer_duration(timer_duration),
        .tx_out(tx_out), .busy(busy), .done(done), .symbol_index(symbol_index)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit   is_done;
        int   idx;
        logic lvl;
        int   dur;
        int   psc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [TW:0] tab [NS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Countdown timer model: pulses after timer_duration enabled cycles.
    logic model_pulse  = 1'b0;
    logic manual_pulse = 1'b0;
    logic tmr_auto     = 1'b1;
    int   tcnt         = 0;
    assign timer_pulse = model_pulse | manual_pulse;

    initial forever begin
        @(negedge clk);
        if (!timer_en) begin
            tcnt        = 0;
            model_pulse = 1'b0;
        end else begin
            tcnt++;
            model_pulse = tmr_auto && (tcnt == int'(timer_duration));
        end
    end

    // Monitor: LOAD cycles and done pulses consume scoreboard entries.
    logic [TW-1:0] cap_dur;
    logic [PW-1:0] cap_psc;
    logic          cap_tx;

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!sys_rst) begin
            if (busy && !timer_en) begin
                check("load_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("load_kind", 32'(e.is_done), 32'd0);
                    check("symbol_index", 32'(symbol_index), 32'(e.idx));
                    check("load_tx_out", 32'(tx_out), 32'(e.lvl));
                    check("load_duration", 32'(timer_duration), 32'(e.dur));
                    check("load_prescaler", 32'(timer_prescaler), 32'(e.psc));
                end
                cap_dur = timer_duration;
                cap_psc = timer_prescaler;
                cap_tx  = tx_out;
            end else if (busy && timer_en) begin
                check("run_duration_hold", 32'(timer_duration), 32'(cap_dur));
                check("run_prescaler_hold", 32'(timer_prescaler), 32'(cap_psc));
                check("run_tx_hold", 32'(tx_out), 32'(cap_tx));
            end
            if (done) begin
                check("done_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("done_kind", 32'(e.is_done), 32'd1);
                    check("done_tx_out", 32'(tx_out), 32'(e.lvl));
                    check("done_busy", 32'(busy), 32'd0);
                    check("done_timer_en", 32'(timer_en), 32'd0);
                end
            end
        end
    end

    task automatic push_load(input int idx);
        exp_t e;
        e.is_done = 1'b0;
        e.idx     = idx;
        e.lvl     = tab[idx][TW];
        e.dur     = int'(tab[idx][TW-1:0]);
        e.psc     = tab[idx][TW] ? int'(prescaler_hi) : int'(prescaler_lo);
        sb.push_back(e);
    endtask

    task automatic push_done(input logic lvl);
        exp_t e;
        e.is_done = 1'b1;
        e.idx     = 0;
        e.lvl     = lvl;
        e.dur     = 0;
        e.psc     = 0;
        sb.push_back(e);
    endtask

    task automatic push_run(input int count, input int loops);
        for (int p = 0; p <= loops; p++)
            for (int i = 0; i < count; i++) push_load(i);
        push_done(idle_level);
    endtask

    task automatic write_entry(input int a, input logic [TW:0] data);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_addr  = AW'(a);
        cfg_wdata = data;
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (!busy && sb.size() == 0) break;
        end
        check({name, "_completes"}, 32'(i < budget), 32'd1);
    endtask

    task automatic wait_run(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (timer_en) break;
        end
        check({name, "_reaches_run"}, 32'(i < budget), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_timer_en"}, 32'(timer_en), 32'd0);
        check({tag, "_tx_out"}, 32'(tx_out), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_symbol_index"}, 32'(symbol_index), 32'd0);
        check({tag, "_timer_prescaler"}, 32'(timer_prescaler), 32'd0);
        check({tag, "_timer_duration"}, 32'(timer_duration), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0] = {1'b1, 8'd5};
        tab[1] = {1'b0, 8'd3};
        tab[2] = {1'b1, 8'd4};
        tab[3] = {1'b0, 8'd2};
        tab[4] = {1'b1, 8'd2};
        tab[5] = {1'b0, 8'd3};
        tab[6] = {1'b1, 8'd1};
        tab[7] = {1'b0, 8'd2};

        sys_rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        prescaler_hi = '0; prescaler_lo = '0; symbol_count = '0; loop_count = '0;
        idle_level = 1'b0; start = 1'b0; stop = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        sys_rst = 1'b0;

        for (int i = 0; i < NS; i++) write_entry(i, tab[i]);

        // Single pass, both prescalers 0
        symbol_count = 4'd2; loop_count = 8'd0; idle_level = 1'b1;
        push_run(2, 0);
        pulse_start();
        wait_idle("single_pass", 200);
        check("single_pass_idle_tx", 32'(tx_out), 32'd1);

        // Prescaler selection by entry level
        prescaler_hi = 4'd3; prescaler_lo = 4'd1;
        symbol_count = 4'd3; loop_count = 8'd0; idle_level = 1'b0;
        push_run(3, 0);
        pulse_start();
        wait_idle("prescaler_select", 200);

        // Three symbols, three passes -> nine loads
        symbol_count = 4'd3; loop_count = 8'd2; idle_level = 1'b1;
        push_run(3, 2);
        pulse_start();
        wait_idle("looping", 500);

        // symbol_count above table depth clamps to the full table
        symbol_count = 4'd9; loop_count = 8'd0; idle_level = 1'b0;
        push_run(8, 0);
        pulse_start();
        wait_idle("count_clamp", 500);

        // Stop with a simultaneous timer pulse
        tmr_auto = 1'b0;
        symbol_count = 4'd2; loop_count = 8'd0; idle_level = 1'b1;
        push_load(0);
        pulse_start();
        wait_run("stop", 20);
        repeat (2) @(negedge clk);
        stop = 1'b1; manual_pulse = 1'b1;
        @(negedge clk);
        stop = 1'b0; manual_pulse = 1'b0;
        #1;
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_timer_en", 32'(timer_en), 32'd0);
        check("stop_tx_out", 32'(tx_out), 32'd1);
        check("stop_no_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        tmr_auto = 1'b1;

        // Zero-length sequence: done next cycle, tx_out left where it was
        idle_level = 1'b0; symbol_count = 4'd0;
        push_done(1'b1);
        pulse_start();
        #1;
        check("zero_count_busy", 32'(busy), 32'd0);
        wait_idle("zero_count", 20);

        // Config write and start while busy are ignored
        symbol_count = 4'd1; loop_count = 8'd0; idle_level = 1'b0;
        push_run(1, 0);
        pulse_start();
        wait_run("busy_write", 20);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = '0; cfg_wdata = {1'b0, 8'd7}; start = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0; start = 1'b0;
        wait_idle("busy_write_run1", 200);
        push_run(1, 0);
        pulse_start();
        wait_idle("busy_write_run2", 200);

        // Reset in the middle of RUN, then table must still be intact
        tmr_auto = 1'b0;
        symbol_count = 4'd2; idle_level = 1'b1;
        push_load(0);
        pulse_start();
        wait_run("mid_reset", 20);
        @(negedge clk);
        sys_rst = 1'b1;
        @(negedge clk);
        sys_rst = 1'b0;
        #1;
        check_reset_outputs("mid_run_reset");
        tmr_auto = 1'b1;
        prescaler_hi = '0; prescaler_lo = '0;
        symbol_count = 4'd2; loop_count = 8'd0; idle_level = 1'b1;
        push_run(2, 0);
        pulse_start();
        wait_idle("after_reset", 200);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
